// File: rtl/pagerank_pkg.sv
// Shared types for the serial PageRank scatter datapath.
// Default widths live here; the engine re-parametrises them per instance.
package pagerank_pkg;

  localparam int DEF_RANK_W = 32;
  localparam int DEF_ID_W   = 32;
  localparam int FRAC_W     = DEF_RANK_W - 1;

  typedef logic [DEF_RANK_W-1:0] rank_t;
  typedef logic [DEF_ID_W-1:0]   node_id_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_EMIT
  } scatter_state_t;

endpackage

// File: rtl/pagerank_serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// A zero divisor naturally yields an all-ones quotient.
module pagerank_serial_divider #(
  parameter int W     = 32,
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [W-1:0]     dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     quotient
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem;
  logic [W-1:0]  quo;
  logic [CW-1:0] cnt;
  logic [W:0]    trial;
  logic [W:0]    dvs;
  logic          ge;
  logic [W-1:0]  rem_n;

  assign dvs   = (W + 1)'(divisor);
  assign trial = {rem, quo[W-1]};
  assign ge    = (trial >= dvs);
  assign rem_n = ge ? W'(trial - dvs) : W'(trial);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      quo  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        cnt  <= CW'(W);
        rem  <= '0;
        quo  <= dividend;
      end else if (busy) begin
        rem <= rem_n;
        quo <= {quo[W-2:0], ge};
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/pagerank_scatter_stream.sv
// PageRank scatter engine: damping*rank/degree streamed per edge,
// with dangling-rank accumulation for degree-0 sources.
module pagerank_scatter_stream
  import pagerank_pkg::*;
#(
  parameter int ID_W    = 32,
  parameter int DEG_W   = 8,
  parameter int MAX_DEG = 4,
  parameter int RANK_W  = 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ID_W-1:0]         in_src_id,
  input  logic [DEG_W-1:0]        in_out_degree,
  input  logic [MAX_DEG*ID_W-1:0] in_dest_id,
  input  logic [RANK_W-1:0]       in_rank,
  input  logic [RANK_W-1:0]       damping,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ID_W-1:0]         out_src_id,
  output logic [ID_W-1:0]         out_dest_id,
  output logic [RANK_W-1:0]       out_contrib,
  output logic                    out_last,
  output logic [RANK_W+7:0]       dangling_sum,
  output logic [ID_W-1:0]         dangling_count,
  output logic                    deg_overflow,
  input  logic                    stats_clear
);

  localparam int FW = RANK_W - 1;
  localparam int KW = (MAX_DEG > 1) ? $clog2(MAX_DEG) : 1;
  localparam int SW = RANK_W + 8;

  scatter_state_t state, state_n;

  logic [ID_W-1:0]     src_q;
  logic [DEG_W-1:0]    deg_q;
  logic [ID_W-1:0]     dest_q [MAX_DEG];
  logic [ID_W-1:0]     dest_in [MAX_DEG];
  logic [RANK_W-1:0]   rank_q;
  logic [RANK_W-1:0]   damp_q;
  logic [RANK_W-1:0]   contrib_q;
  logic [KW-1:0]       k;

  logic                accept;
  logic                fire;
  logic                dangling;
  logic [DEG_W-1:0]    n;
  logic [2*RANK_W-1:0] prod;
  logic [RANK_W-1:0]   scaled;
  logic [SW:0]         dsum_ext;
  logic [SW-1:0]       dsum_n;

  logic                div_busy;
  logic                div_done;
  logic [RANK_W-1:0]   div_quo;

  assign in_ready  = (state == S_IDLE) && reset_n;
  assign accept    = in_valid && in_ready;
  assign dangling  = (in_out_degree == '0);
  assign out_valid = (state == S_EMIT);
  assign fire      = out_valid && out_ready;

  // Only the first MAX_DEG edges are streamed; the divisor keeps the full degree.
  assign n = (deg_q > DEG_W'(MAX_DEG)) ? DEG_W'(MAX_DEG) : deg_q;

  assign prod   = {{RANK_W{1'b0}}, rank_q} * {{RANK_W{1'b0}}, damp_q};
  assign scaled = RANK_W'(prod >> FW);

  assign dsum_ext = {1'b0, dangling_sum} + (SW + 1)'(in_rank);
  assign dsum_n   = dsum_ext[SW] ? '1 : dsum_ext[SW-1:0];

  always_comb begin
    for (int i = 0; i < MAX_DEG; i++) begin
      dest_in[i] = in_dest_id[i*ID_W +: ID_W];
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (accept && !dangling) state_n = S_MUL;
      S_MUL:  state_n = S_DIV;
      S_DIV:  if (div_done && !div_busy) state_n = S_EMIT;
      S_EMIT: if (fire && out_last) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      src_q     <= '0;
      deg_q     <= '0;
      rank_q    <= '0;
      damp_q    <= '0;
      contrib_q <= '0;
      k         <= '0;
      for (int i = 0; i < MAX_DEG; i++) dest_q[i] <= '0;
    end else begin
      if (accept) begin
        src_q  <= in_src_id;
        deg_q  <= in_out_degree;
        rank_q <= in_rank;
        damp_q <= damping;
        k      <= '0;
        for (int i = 0; i < MAX_DEG; i++) dest_q[i] <= dest_in[i];
      end
      if (state == S_DIV && div_done) contrib_q <= div_quo;
      if (fire && !out_last) k <= k + 1'b1;
    end
  end

  // A clear in the same cycle as a dangling accept drops that accumulate.
  always_ff @(posedge clock) begin
    if (!reset_n || stats_clear) begin
      dangling_sum   <= '0;
      dangling_count <= '0;
      deg_overflow   <= 1'b0;
    end else if (accept) begin
      if (dangling) begin
        dangling_sum   <= dsum_n;
        dangling_count <= dangling_count + 1'b1;
      end
      if (in_out_degree > DEG_W'(MAX_DEG)) deg_overflow <= 1'b1;
    end
  end

  assign out_src_id  = src_q;
  assign out_dest_id = dest_q[k];
  assign out_contrib = contrib_q;
  assign out_last    = out_valid && (DEG_W'(k) == n - DEG_W'(1));

  pagerank_serial_divider #(
    .W     (RANK_W),
    .DIV_W (DEG_W)
  ) u_div (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (state == S_MUL),
    .dividend (scaled),
    .divisor  (deg_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

endmodule
